// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select and front-end stall/flush controller for the 5-stage MIPS core.
// Optional stall performance counter is enabled with `define HAZ_PERF_CNT_EN.
module fwd_hazard_ctrl #(
  parameter int MULDIV_LAT = 4
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs_Id,
  input  logic [4:0] Rt_Id,
  input  logic       UsesRt_Id,
  input  logic [4:0] WriteReg_Id,
  input  logic       RegWrite_Id,
  input  logic       MemRead_Id,
  input  logic       MulDiv_Id,
  input  logic       BranchTaken_Ex,
  output logic [1:0] FA,
  output logic [1:0] FB,
  output logic       Stall_PC,
  output logic       Stall_IfId,
  output logic       Flush_IfId,
  output logic       Flush_IdEx
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0] Stall_Cnt
`endif
);

  localparam logic [1:0] SEL_IDEX = 2'b00;
  localparam logic [1:0] SEL_WB   = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;
  localparam logic [2:0] CNT_LOAD = (MULDIV_LAT > 1) ? 3'(MULDIV_LAT - 2) : 3'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;

  logic [4:0] ex_rs, ex_rt, ex_wr;
  logic       ex_usesrt, ex_regwr, ex_memrd, ex_muldiv;
  logic [4:0] mem_wr, wb_wr;
  logic       mem_regwr, wb_regwr;

  logic busy;
  logic load_use;
  logic fwd_mem_a, fwd_wb_a, fwd_mem_b, fwd_wb_b;

  assign busy = (state == BUSY);

  // While a mul/div is busy the EX slot is held, so a load there cannot be bubbled out.
  assign load_use = ex_memrd && (ex_wr != 5'd0) && !busy &&
                    ((ex_wr == Rs_Id) || (UsesRt_Id && (ex_wr == Rt_Id)));

  assign fwd_mem_a = mem_regwr && (mem_wr != 5'd0) && (mem_wr == ex_rs);
  assign fwd_wb_a  = wb_regwr  && (wb_wr  != 5'd0) && (wb_wr  == ex_rs);
  assign fwd_mem_b = ex_usesrt && mem_regwr && (mem_wr != 5'd0) && (mem_wr == ex_rt);
  assign fwd_wb_b  = ex_usesrt && wb_regwr  && (wb_wr  != 5'd0) && (wb_wr  == ex_rt);

  always_comb begin
    FA         = SEL_IDEX;
    FB         = SEL_IDEX;
    Stall_PC   = 1'b0;
    Stall_IfId = 1'b0;
    Flush_IfId = 1'b0;
    Flush_IdEx = 1'b0;
    if (rst) begin
      if (fwd_mem_a)     FA = SEL_MEM;
      else if (fwd_wb_a) FA = SEL_WB;
      if (fwd_mem_b)     FB = SEL_MEM;
      else if (fwd_wb_b) FB = SEL_WB;
      // A taken branch discards the stalled instruction anyway, so it wins over load-use.
      Stall_PC   = busy || (load_use && !BranchTaken_Ex);
      Stall_IfId = busy || (load_use && !BranchTaken_Ex);
      Flush_IfId = BranchTaken_Ex;
      Flush_IdEx = BranchTaken_Ex || load_use;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (ex_muldiv && !BranchTaken_Ex && (MULDIV_LAT > 1)) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt == 3'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 3'd1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Shadow pipeline: MEM gets a bubble while busy; EX bubbles on flush, holds while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_rs     <= 5'd0;
      ex_rt     <= 5'd0;
      ex_usesrt <= 1'b0;
      ex_wr     <= 5'd0;
      ex_regwr  <= 1'b0;
      ex_memrd  <= 1'b0;
      ex_muldiv <= 1'b0;
      mem_wr    <= 5'd0;
      mem_regwr <= 1'b0;
      wb_wr     <= 5'd0;
      wb_regwr  <= 1'b0;
    end else begin
      mem_wr    <= busy ? 5'd0 : ex_wr;
      mem_regwr <= busy ? 1'b0 : ex_regwr;
      wb_wr     <= mem_wr;
      wb_regwr  <= mem_regwr;
      if (Flush_IdEx) begin
        ex_rs     <= 5'd0;
        ex_rt     <= 5'd0;
        ex_usesrt <= 1'b0;
        ex_wr     <= 5'd0;
        ex_regwr  <= 1'b0;
        ex_memrd  <= 1'b0;
        ex_muldiv <= 1'b0;
      end else if (!busy) begin
        ex_rs     <= Rs_Id;
        ex_rt     <= Rt_Id;
        ex_usesrt <= UsesRt_Id;
        ex_wr     <= WriteReg_Id;
        ex_regwr  <= RegWrite_Id;
        ex_memrd  <= MemRead_Id;
        ex_muldiv <= MulDiv_Id;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      Stall_Cnt <= '0;
    else if (Stall_PC && (Stall_Cnt != {CNT_W{1'b1}}))
      Stall_Cnt <= Stall_Cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: each cycle drives one ID-stage instruction and
// queues the hand-derived control outputs, which are popped and compared before the next edge.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs_Id, Rt_Id, WriteReg_Id;
  logic       UsesRt_Id, RegWrite_Id, MemRead_Id, MulDiv_Id, BranchTaken_Ex;
  logic [1:0] FA, FB;
  logic       Stall_PC, Stall_IfId, Flush_IfId, Flush_IdEx;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] Stall_Cnt;
`endif

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       stall;
    logic       flushif;
    logic       flushex;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;

  fwd_hazard_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .Rs_Id          (Rs_Id),
    .Rt_Id          (Rt_Id),
    .UsesRt_Id      (UsesRt_Id),
    .WriteReg_Id    (WriteReg_Id),
    .RegWrite_Id    (RegWrite_Id),
    .MemRead_Id     (MemRead_Id),
    .MulDiv_Id      (MulDiv_Id),
    .BranchTaken_Ex (BranchTaken_Ex),
    .FA             (FA),
    .FB             (FB),
    .Stall_PC       (Stall_PC),
    .Stall_IfId     (Stall_IfId),
    .Flush_IfId     (Flush_IfId),
    .Flush_IdEx     (Flush_IdEx)
`ifdef HAZ_PERF_CNT_EN
    , .Stall_Cnt    (Stall_Cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t mkExp(logic [1:0] fa, logic [1:0] fb, logic st, logic fi, logic fe);
    exp_t e;
    e.fa = fa; e.fb = fb; e.stall = st; e.flushif = fi; e.flushex = fe;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic sampleOutputs(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput({tag, ".sb_empty"}, 16'd1, 16'd0);
      return;
    end
    e = expQ.pop_front();
    checkOutput({tag, ".FA"},         16'(FA),         16'(e.fa));
    checkOutput({tag, ".FB"},         16'(FB),         16'(e.fb));
    checkOutput({tag, ".Stall_PC"},   16'(Stall_PC),   16'(e.stall));
    checkOutput({tag, ".Stall_IfId"}, 16'(Stall_IfId), 16'(e.stall));
    checkOutput({tag, ".Flush_IfId"}, 16'(Flush_IfId), 16'(e.flushif));
    checkOutput({tag, ".Flush_IdEx"}, 16'(Flush_IdEx), 16'(e.flushex));
  endtask

  task automatic driveId(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic [4:0] wr, input logic rw, input logic mr,
                         input logic md, input logic br);
    Rs_Id = rs; Rt_Id = rt; UsesRt_Id = urt; WriteReg_Id = wr;
    RegWrite_Id = rw; MemRead_Id = mr; MulDiv_Id = md; BranchTaken_Ex = br;
  endtask

  // One pipeline cycle: the ID instruction is driven at the falling edge, outputs checked 1ns later.
  task automatic applyStimulus(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urt, input logic [4:0] wr, input logic rw,
                               input logic mr, input logic md, input logic br, input exp_t e);
    @(negedge clk);
    driveId(rs, rt, urt, wr, rw, mr, md, br);
    expQ.push_back(e);
    #1;
    sampleOutputs(tag);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b0;
    driveId(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Outputs stay quiet in reset even with a live branch and load-like ID instruction
    @(negedge clk);
    driveId(5'd8, 5'd8, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1);
    expQ.push_back(mkExp(2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    #1;
    sampleOutputs("in_reset");
`ifdef HAZ_PERF_CNT_EN
    checkOutput("in_reset.Stall_Cnt", Stall_Cnt, 16'd0);
`endif
    driveId(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;

    // add $3 <- $1,$2 ; sub $4 <- $3,$5 ; or $6 <- $7,$3
    applyStimulus("fwd_add3",  5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("fwd_sub4",  5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("fwd_memA",  5'd7, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, mkExp(2'b10, 2'b00, 0, 0, 0));
    applyStimulus("fwd_wbB",   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b01, 0, 0, 0));
    applyStimulus("fwd_drain", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));

    // Two writers of $3 back to back: the younger one in MEM must win over WB
    applyStimulus("pri_addA",  5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("pri_addB",  5'd4, 5'd5, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("pri_read",  5'd3, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("pri_memAB", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, mkExp(2'b10, 2'b10, 0, 0, 0));
    applyStimulus("pri_drain", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));

    // Writes to $0 in MEM and WB while EX reads $0
    applyStimulus("r0_wA",     5'd1, 5'd1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("r0_wB",     5'd2, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("r0_read",   5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("r0_noFwd",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));

    // lw $8 ; add $9 <- $8,$8
    applyStimulus("lu_lw8",    5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("lu_stall",  5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 1, 0, 1));
    applyStimulus("lu_bubble", 5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("lu_wbFwd",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, mkExp(2'b01, 2'b01, 0, 0, 0));

    // Load-use coinciding with a taken branch: flush both, no stall
    applyStimulus("br_lw10",   5'd2, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("br_flush",  5'd10, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1, mkExp(2'b00, 2'b00, 0, 1, 1));
    applyStimulus("br_after",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));

    // mult ; add : three stall cycles, never a bubble into ID/EX
    applyStimulus("md_mult",   5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("md_add",    5'd11, 5'd12, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("md_busy%0d", i), 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                    mkExp(2'b00, 2'b00, 1, 0, 0));
    applyStimulus("md_release", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("md_idle",    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
`ifdef HAZ_PERF_CNT_EN
    checkOutput("perf.Stall_Cnt", Stall_Cnt, 16'd4);
`endif

    // Second mult, then reset pulsed while busy
    applyStimulus("rb_mult",   5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("rb_ex",     5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("rb_busy",   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 1, 0, 0));
    rst = 1'b0;
    BranchTaken_Ex = 1'b1;
    expQ.push_back(mkExp(2'b00, 2'b00, 0, 0, 0));
    #1;
    sampleOutputs("rb_inreset");
`ifdef HAZ_PERF_CNT_EN
    checkOutput("rb_inreset.Stall_Cnt", Stall_Cnt, 16'd0);
`endif
    BranchTaken_Ex = 1'b0;
    #1 rst = 1'b1;
    applyStimulus("rb_empty0", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("rb_empty1", 5'd13, 5'd13, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
    applyStimulus("rb_empty2", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, mkExp(2'b00, 2'b00, 0, 0, 0));
`ifdef HAZ_PERF_CNT_EN
    checkOutput("rb_after.Stall_Cnt", Stall_Cnt, 16'd0);
`endif

    checkOutput("sb_drained", 16'(expQ.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
